// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - shared constants and types for the Simplez I/O peripherals
package simplez_pkg;

    localparam int DATAW_DEF = 12;
    localparam int ADDRW_DEF = 9;

    // Memory-mapped I/O window at the top of the 512-word address space
    localparam int SCREEN_STATUS_ADDR = 508;
    localparam int SCREEN_DATA_ADDR   = 509;
    localparam int KBD_STATUS_ADDR    = 510;
    localparam int KBD_DATA_ADDR      = 511;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/simplez_uart_tx_baud_gen.sv
// rtl/simplez_uart_tx_baud_gen.sv - bit-period counter with synchronous clear and wrap tick
module baud_gen #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // tick marks the last cycle of a bit period; suppressed while held clear
    assign tick = (cnt == LAST) && !clr;

    // count 0..BAUD_DIV-1, restart on clear or wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/simplez_uart_tx.sv
// rtl/simplez_uart_tx.sv - Simplez screen device: bus-mapped 8N1 serial transmitter
module simplez_uart_tx
    import simplez_pkg::*;
#(
    parameter int DATAW       = DATAW_DEF,
    parameter int ADDRW       = ADDRW_DEF,
    parameter int BAUD_DIV    = 104,
    parameter int STATUS_ADDR = SCREEN_STATUS_ADDR,
    parameter int DATA_ADDR   = SCREEN_DATA_ADDR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             tx,
    output logic             busy
);

    localparam logic [ADDRW-1:0] A_STATUS = ADDRW'(STATUS_ADDR);
    localparam logic [ADDRW-1:0] A_DATA   = ADDRW'(DATA_ADDR);

    tx_state_t  state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       overrun;
    logic       tick;

    logic sel_status_rd;
    logic sel_data_rd;
    logic data_wr;
    logic is_idle;
    logic unused_hi;

    assign sel_status_rd = rd && (addr == A_STATUS);
    assign sel_data_rd   = rd && (addr == A_DATA);
    assign data_wr       = wr && (addr == A_DATA);
    assign is_idle       = (state == ST_IDLE);

    // upper data bits have no meaning for the screen device
    assign unused_hi = ^data_in[DATAW-1:8];

    // counter is held at zero in IDLE so START always gets a full bit period
    baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (is_idle),
        .tick (tick)
    );

    // frame sequencer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_wr) begin
                        shreg   <= data_in[7:0];
                        state   <= ST_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // overrun flag: a data write while not idle sets it, a status read clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (data_wr && !is_idle) begin
            overrun <= 1'b1;
        end else if (sel_status_rd) begin
            overrun <= 1'b0;
        end
    end

    // registered read port, zero when not addressed so the bus can OR it in
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
        end else if (sel_status_rd) begin
            data_out <= {{(DATAW-2){1'b0}}, overrun, is_idle};
        end else if (sel_data_rd) begin
            data_out <= {{(DATAW-8){1'b0}}, shreg};
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// tb/tb_simplez_uart_tx.sv - directed table and sequence bench for simplez_uart_tx
module tb_simplez_uart_tx;

    localparam int BD   = 4;
    localparam int NONE = -10;

    logic        clk;
    logic        rstn;
    logic [8:0]  addr;
    logic        rd;
    logic        wr;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        tx;
    logic        busy;

    int checks;
    int errors;

    simplez_uart_tx #(
        .DATAW       (12),
        .ADDRW       (9),
        .BAUD_DIV    (BD),
        .STATUS_ADDR (508),
        .DATA_ADDR   (509)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [8:0]  addr;
        logic        rd;
        logic        wr;
        logic [11:0] din;
        logic [11:0] exp_dout;
        logic        exp_busy;
        logic        exp_tx;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input string name, input logic [8:0] a, input logic [11:0] exp);
        addr = a;
        rd   = 1'b1;
        @(negedge clk);
        check(name, {20'b0, data_out}, {20'b0, exp});
        rd = 1'b0;
    endtask

    // Starts a frame at the current negedge and checks the line for 10 bit periods.
    // Optionally injects one data write at sample wr_k and status reads at rk1/rk2.
    task automatic run_frame(input string name, input logic [11:0] d,
                             input int wr_k, input logic [11:0] wr_d,
                             input int rk1, input logic [11:0] e1,
                             input int rk2, input logic [11:0] e2);
        logic [9:0] fb;
        fb      = {1'b1, d[7:0], 1'b0};
        addr    = 9'd509;
        data_in = d;
        wr      = 1'b1;
        rd      = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        for (int k = 0; k < 10 * BD; k++) begin
            check($sformatf("%s tx[%0d]", name, k), {31'b0, tx}, {31'b0, fb[k / BD]});
            if (k == 0)
                check({name, " busy_rise"}, {31'b0, busy}, 32'd1);
            if (k == rk1 + 1)
                check({name, " status_rd1"}, {20'b0, data_out}, {20'b0, e1});
            if (k == rk2 + 1)
                check({name, " status_rd2"}, {20'b0, data_out}, {20'b0, e2});
            rd      = (k == rk1) || (k == rk2);
            wr      = (k == wr_k);
            addr    = rd ? 9'd508 : 9'd509;
            data_in = wr_d;
            @(negedge clk);
        end
        rd = 1'b0;
        wr = 1'b0;
        check({name, " busy_end"}, {31'b0, busy}, 32'd0);
        check({name, " tx_end"}, {31'b0, tx}, 32'd1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;

        vecs[0] = '{"rd_status",     9'd508, 1'b1, 1'b0, 12'h000, 12'h001, 1'b0, 1'b1};
        vecs[1] = '{"rd_data_reset", 9'd509, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[2] = '{"rd_miss_300",   9'd300, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[3] = '{"wr_status",     9'd508, 1'b0, 1'b1, 12'hFFF, 12'h000, 1'b0, 1'b1};
        vecs[4] = '{"rd_status_2",   9'd508, 1'b1, 1'b0, 12'h000, 12'h001, 1'b0, 1'b1};
        vecs[5] = '{"rd_kbd_510",    9'd510, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[6] = '{"rd_kbd_511",    9'd511, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[7] = '{"no_rd_status",  9'd508, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[8] = '{"rdwr_status",   9'd508, 1'b1, 1'b1, 12'h0AB, 12'h001, 1'b0, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        check("reset tx", {31'b0, tx}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset data_out", {20'b0, data_out}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // single-cycle bus decode vectors
        for (int i = 0; i < 9; i++) begin
            addr    = vecs[i].addr;
            rd      = vecs[i].rd;
            wr      = vecs[i].wr;
            data_in = vecs[i].din;
            @(negedge clk);
            check(vecs[i].name, {18'b0, data_out, busy, tx},
                  {18'b0, vecs[i].exp_dout, vecs[i].exp_busy, vecs[i].exp_tx});
            rd = 1'b0;
            wr = 1'b0;
        end

        // single frame
        run_frame("f41", 12'hA41, NONE, 12'h000, NONE, 12'h000, NONE, 12'h000);
        read_reg("f41 status", 9'd508, 12'h001);
        read_reg("f41 data", 9'd509, 12'h041);

        // overrun during a frame
        run_frame("ovr", 12'h055, 9, 12'h0FF, 20, 12'h002, 25, 12'h000);
        read_reg("ovr status_after", 9'd508, 12'h001);
        read_reg("ovr data", 9'd509, 12'h055);

        // write on the last STOP cycle is dropped; write on the following idle edge starts at once
        run_frame("stopedge", 12'h0A5, 10 * BD - 1, 12'h0FF, NONE, 12'h000, NONE, 12'h000);
        run_frame("b2b", 12'h03C, NONE, 12'h000, 5, 12'h002, 7, 12'h000);
        read_reg("b2b status", 9'd508, 12'h001);
        read_reg("b2b data", 9'd509, 12'h03C);

        // reset during data bit 3
        addr    = 9'd509;
        data_in = 12'h0C3;
        wr      = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (4 * BD + 1) @(negedge clk);
        check("midrst bit3", {31'b0, tx}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("midrst tx_async", {31'b0, tx}, 32'd1);
        check("midrst busy_async", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3 * BD; c++) begin
            @(negedge clk);
            check($sformatf("midrst idle_line[%0d]", c), {30'b0, busy, tx}, 32'd1);
        end
        read_reg("midrst status", 9'd508, 12'h001);
        read_reg("midrst data", 9'd509, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
